dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Sequences and shares the single-ported 64-word data memory between two requesters: port 0 (pipeline MEM stage, lw/sw) and port 1 (loader/debug port).
- Adds programmable wait states, so the pipeline can be stalled against a slow memory model.
- Performs range checking.
- Sits between the requesters and the memory's Address/WriteData/MemRead/MemWrite/ReadData pins.

Parameters:
- WAIT_CYCLES, 1: extra cycles per access; BUSY lasts WAIT_CYCLES+1 cycles. Legal range 0..15.
- MEM_WORDS, 64: words implemented by memory. Byte addresses >= 4*MEM_WORDS are out of range.
- ARB_MODE, 1: 0 = fixed priority (port 0 wins), 1 = round-robin.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- p0_req  in  1  port 0 access request, level, held until p0_done
- p0_we  in  1  1 = write, 0 = read
- p0_addr  in  32  byte address; bits [1:0] ignored
- p0_wdata  in  32  write data
- p0_done  out  1  one-cycle completion pulse
- p0_rdata  out  32  read data, valid while p0_done=1
- p0_err  out  1  out-of-range flag, valid while p0_done=1
- p1_req, p1_we, p1_addr, p1_wdata, p1_done, p1_rdata, p1_err: same meanings for port 1
- mem_addr  out  32  to memory Address
- mem_wdata  out  32  to memory WriteData
- mem_read  out  1  to memory MemRead
- mem_write  out  1  to memory MemWrite
- mem_rdata  in  32  from memory ReadData (combinational)
- busy  out  1  high in BUSY state

Behaviour:
- **Clocking and reset:** one clock; reset is asynchronous and active-high.
- **Reset values:** state=IDLE, last_grant=1, all outputs 0 (rdata 0, done 0, err 0, mem_* 0).
- **States:**
  - IDLE: evaluate requests each cycle.
  - BUSY: owner holds the memory; counter cnt counts down from WAIT_CYCLES.
- **IDLE transitions:**
  - No eligible request: stay in IDLE.
  - Otherwise pick winner, latch owner/we/addr/wdata, set cnt=WAIT_CYCLES, go to BUSY.
  - If the winner's address is out of range: stay in IDLE, no memory strobe, pulse done and err next cycle, rdata=0.
- **Eligibility:** a port whose done is high this cycle is NOT eligible. The requester must drop req in its done cycle; re-raising req the following cycle is a new access.
- **Arbitration:**
  - ARB_MODE=0: port 0 always wins a tie.
  - ARB_MODE=1: a tie goes to the port not equal to last_grant.
  - last_grant updates on every accepted access, including err accesses.
- **BUSY outputs:**
  - mem_addr = latched addr, mem_wdata = latched wdata, held for the whole BUSY state.
  - mem_read = !we, held for the whole BUSY state.
  - mem_write = we && cnt==0, so the write commits at the clock edge ending the last BUSY cycle, exactly once.
- **BUSY countdown:** cnt decrements each cycle.
- **BUSY exit (cnt==0):**
  - At the edge, owner rdata <= (we ? 0 : mem_rdata) and owner done <= 1 (registered, lasts one cycle).
  - State returns to IDLE; mem_* go to 0.
- **Latency:** req sampled in IDLE at cycle T → done high in cycle T+WAIT_CYCLES+2. Non-owner req is held pending, with no done.
- **Output holding:** rdata holds its value until the next completion on that port. err clears on the next done.
- **Request changes during BUSY:** changes on the owner's addr/wdata/we are ignored (latched copy is used). Owner dropping req mid-BUSY does not abort the access.
- **Reset mid-BUSY:** access is aborted, mem_write drops immediately, no done is generated, and memory contents are untouched.
- **Throughput:** maximum one access per WAIT_CYCLES+2 cycles. There is no back-to-back issue in a done cycle for the same port; the other port may be accepted in that cycle.

Decomposition:
- Package dmem_arb_pkg:
  - state enum {IDLE, BUSY}
  - ARB_FIXED=0, ARB_RR=1
  - WAIT_W=4 (cnt width)
- Sub-module rr_arb2: combinational 2-way picker. Inputs: req[1:0], last_grant, mode. Outputs: gnt_valid, gnt_id.
- All state, latching and the counter live in dmem_arbiter.

Test Plan:
- **Basic read:** WAIT_CYCLES=2, memory word 5 = 32'hDEADBEEF; p0 read addr 20 at cycle 0 → mem_read high in cycles 1-3; p0_done in cycle 4 with p0_rdata=DEADBEEF, p0_err=0.
- **Write then read:** p1 write addr 8, data 32'h12345678 → exactly one mem_write cycle (cycle 3); a subsequent p1 read of addr 8 returns 12345678.
- **Round-robin tie:** ARB_MODE=1, p0 and p1 request simultaneously and continuously from reset → grant order p0, p1, p0, p1. Each done is one cycle. Each port is re-accepted only after dropping req in its done cycle.
- **Fixed-priority starvation:** ARB_MODE=0, p0 requesting continuously (re-raising after each done) and p1 requesting → p1 is granted only in p0's done cycles.
- **Out of range:** p0 read addr 256 → no mem_read/mem_write ever; p0_done and p0_err high at cycle 1, p0_rdata=0.
- **Reset mid-operation:** p0 write addr 4, reset asserted in cycle 2 → mem_write never pulses, memory word 1 is unchanged, all outputs are 0 immediately, and IDLE accepts a new request after reset release.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Pure declarations; no logic, no latency.
package dmem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;

    localparam int WAIT_W = 4;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester ports, memory pins and busy flag of the data-memory arbiter.
// The slave modport is the arbiter side; master is the requesters plus memory.
interface dmem_arbiter_if;

    logic        p0_req;
    logic        p0_we;
    logic [31:0] p0_addr;
    logic [31:0] p0_wdata;
    logic        p0_done;
    logic [31:0] p0_rdata;
    logic        p0_err;

    logic        p1_req;
    logic        p1_we;
    logic [31:0] p1_addr;
    logic [31:0] p1_wdata;
    logic        p1_done;
    logic [31:0] p1_rdata;
    logic        p1_err;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;
    logic        busy;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_done, p0_rdata, p0_err,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_done, p1_rdata, p1_err,
        output mem_addr, mem_wdata, mem_read, mem_write,
        input  mem_rdata,
        output busy
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_done, p0_rdata, p0_err,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_done, p1_rdata, p1_err,
        input  mem_addr, mem_wdata, mem_read, mem_write,
        output mem_rdata,
        input  busy
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way combinational picker: fixed priority to port 0, or round-robin on ties.
// Zero latency; no backpressure of its own.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       mode,
    output logic       gnt_valid,
    output logic       gnt_id
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = 1'b0;
        if (req == 2'b10) begin
            gnt_id = 1'b1;
        end else if (req == 2'b11 && mode == ARB_RR) begin
            gnt_id = ~last_grant;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-ported data memory between two requesters, with wait states and range check.
// Accepted request completes WAIT_CYCLES+2 cycles later; a non-owner request waits pending.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int MEM_WORDS   = 64,
    parameter int ARB_MODE    = 1
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

    localparam logic [31:0]       ADDR_LIMIT = 32'(4 * MEM_WORDS);
    localparam logic [WAIT_W-1:0] WAIT_INIT  = WAIT_W'(WAIT_CYCLES);
    localparam logic              MODE       = 1'(ARB_MODE);

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic [1:0]        done_q, done_d;
    logic [1:0]        err_q, err_d;
    logic [1:0][31:0]  rdata_q, rdata_d;

    logic [1:0]  elig;
    logic        gnt_valid;
    logic        gnt_id;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;

    // A port in its done cycle must not be re-accepted; its req still reflects the finished access.
    assign elig = {bus.p1_req, bus.p0_req} & ~done_q;

    rr_arb2 u_pick (
        .req        (elig),
        .last_grant (last_grant_q),
        .mode       (MODE),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    assign sel_we    = gnt_id ? bus.p1_we    : bus.p0_we;
    assign sel_addr  = gnt_id ? bus.p1_addr  : bus.p0_addr;
    assign sel_wdata = gnt_id ? bus.p1_wdata : bus.p0_wdata;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        done_d       = '0;
        err_d        = err_q;
        rdata_d      = rdata_q;

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    last_grant_d = gnt_id;
                    if (sel_addr >= ADDR_LIMIT) begin
                        done_d[gnt_id]  = 1'b1;
                        err_d[gnt_id]   = 1'b1;
                        rdata_d[gnt_id] = '0;
                    end else begin
                        state_d = BUSY;
                        owner_d = gnt_id;
                        we_d    = sel_we;
                        addr_d  = sel_addr;
                        wdata_d = sel_wdata;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d          = IDLE;
                    done_d[owner_q]  = 1'b1;
                    err_d[owner_q]   = 1'b0;
                    rdata_d[owner_q] = we_q ? 32'h0 : bus.mem_rdata;
                end else begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            done_q       <= '0;
            err_q        <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
        end
    end

    // Memory strobes come straight from state so reset kills a pending write immediately.
    assign bus.busy      = (state_q == BUSY);
    assign bus.mem_addr  = bus.busy ? addr_q  : 32'h0;
    assign bus.mem_wdata = bus.busy ? wdata_q : 32'h0;
    assign bus.mem_read  = bus.busy && !we_q;
    assign bus.mem_write = bus.busy && we_q && (cnt_q == '0);

    assign bus.p0_done  = done_q[0];
    assign bus.p0_err   = err_q[0];
    assign bus.p0_rdata = rdata_q[0];
    assign bus.p1_done  = done_q[1];
    assign bus.p1_err   = err_q[1];
    assign bus.p1_rdata = rdata_q[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: round-robin instance (WAIT_CYCLES=2) with a memory model,
// plus a fixed-priority instance (WAIT_CYCLES=0) whose memory returns addr ^ A5A5A5A5.
module tb_dmem_arbiter;

    logic clk;
    logic rst;
    logic mem_clr;
    int   n_assert;
    int   n_fail;
    int   wr_cnt;

    dmem_arbiter_if ifr ();
    dmem_arbiter_if ifp ();

    dmem_arbiter #(.WAIT_CYCLES(2), .MEM_WORDS(64), .ARB_MODE(1)) u_rr (
        .clk   (clk),
        .reset (rst),
        .bus   (ifr)
    );

    dmem_arbiter #(.WAIT_CYCLES(0), .MEM_WORDS(64), .ARB_MODE(0)) u_fp (
        .clk   (clk),
        .reset (rst),
        .bus   (ifp)
    );

    logic [31:0] mem_r [64];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem_r[i] <= 32'h0;
            mem_r[1] <= 32'hCAFEF00D;
            mem_r[5] <= 32'hDEADBEEF;
        end else if (ifr.mem_write) begin
            mem_r[ifr.mem_addr[7:2]] <= ifr.mem_wdata;
        end
    end

    always @(posedge clk) begin
        if (ifr.mem_write) wr_cnt <= wr_cnt + 1;
    end

    assign ifr.mem_rdata = mem_r[ifr.mem_addr[7:2]];
    assign ifp.mem_rdata = ifp.mem_addr ^ 32'hA5A5A5A5;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        wr_cnt   = 0;
        rst      = 1'b1;
        mem_clr  = 1'b1;
        ifr.p0_req = 0; ifr.p0_we = 0; ifr.p0_addr = 0; ifr.p0_wdata = 0;
        ifr.p1_req = 0; ifr.p1_we = 0; ifr.p1_addr = 0; ifr.p1_wdata = 0;
        ifp.p0_req = 0; ifp.p0_we = 0; ifp.p0_addr = 0; ifp.p0_wdata = 0;
        ifp.p1_req = 0; ifp.p1_we = 0; ifp.p1_addr = 0; ifp.p1_wdata = 0;
        repeat (3) tick();

        // Reset state
        chk("rst_busy",   32'(ifr.busy), 0);
        chk("rst_p0done", 32'(ifr.p0_done), 0);
        chk("rst_p1done", 32'(ifr.p1_done), 0);
        chk("rst_p0rd",   ifr.p0_rdata, 0);
        chk("rst_p0err",  32'(ifr.p0_err), 0);
        chk("rst_mread",  32'(ifr.mem_read), 0);
        chk("rst_mwrite", 32'(ifr.mem_write), 0);
        chk("rst_maddr",  ifr.mem_addr, 0);
        mem_clr = 1'b0;
        rst     = 1'b0;
        tick();
        chk("idle_busy", 32'(ifr.busy), 0);

        // Basic read: p0 addr 20 -> word 5
        ifr.p0_req = 1; ifr.p0_we = 0; ifr.p0_addr = 32'd20;
        tick();
        chk("rd_c1_busy",  32'(ifr.busy), 1);
        chk("rd_c1_mread", 32'(ifr.mem_read), 1);
        chk("rd_c1_maddr", ifr.mem_addr, 32'd20);
        tick();
        chk("rd_c2_mread", 32'(ifr.mem_read), 1);
        tick();
        chk("rd_c3_mread", 32'(ifr.mem_read), 1);
        chk("rd_c3_done",  32'(ifr.p0_done), 0);
        tick();
        chk("rd_c4_done",  32'(ifr.p0_done), 1);
        chk("rd_c4_rdata", ifr.p0_rdata, 32'hDEADBEEF);
        chk("rd_c4_err",   32'(ifr.p0_err), 0);
        chk("rd_c4_mread", 32'(ifr.mem_read), 0);
        ifr.p0_req = 0;
        tick();
        chk("rd_c5_done",  32'(ifr.p0_done), 0);
        chk("rd_c5_hold",  ifr.p0_rdata, 32'hDEADBEEF);

        // p1 write addr 8, then read it back; mid-BUSY changes must be ignored
        ifr.p1_req = 1; ifr.p1_we = 1; ifr.p1_addr = 32'd8; ifr.p1_wdata = 32'h12345678;
        tick();
        chk("wr_c1_busy",  32'(ifr.busy), 1);
        chk("wr_c1_mread", 32'(ifr.mem_read), 0);
        chk("wr_c1_mwr",   32'(ifr.mem_write), 0);
        ifr.p1_wdata = 32'hFFFFFFFF; ifr.p1_addr = 32'd12;
        tick();
        chk("wr_c2_mwr",   32'(ifr.mem_write), 0);
        tick();
        chk("wr_c3_mwr",   32'(ifr.mem_write), 1);
        chk("wr_c3_wdata", ifr.mem_wdata, 32'h12345678);
        chk("wr_c3_maddr", ifr.mem_addr, 32'd8);
        tick();
        chk("wr_c4_done",  32'(ifr.p1_done), 1);
        chk("wr_c4_rdata", ifr.p1_rdata, 0);
        chk("wr_c4_mwr",   32'(ifr.mem_write), 0);
        chk("wr_count",    32'(wr_cnt), 1);
        chk("wr_mem2",     mem_r[2], 32'h12345678);
        ifr.p1_req = 0;
        tick();
        ifr.p1_req = 1; ifr.p1_we = 0; ifr.p1_addr = 32'd8;
        repeat (4) tick();
        chk("rb_done",  32'(ifr.p1_done), 1);
        chk("rb_rdata", ifr.p1_rdata, 32'h12345678);
        ifr.p1_req = 0;
        tick();

        // Round-robin with both ports requesting continuously
        ifr.p0_req = 1; ifr.p0_we = 0; ifr.p0_addr = 32'd20;
        ifr.p1_req = 1; ifr.p1_we = 0; ifr.p1_addr = 32'd8;
        for (int c = 1; c <= 16; c++) begin
            tick();
            chk($sformatf("rr_c%0d_p0done", c), 32'(ifr.p0_done), 32'(c == 4 || c == 12));
            chk($sformatf("rr_c%0d_p1done", c), 32'(ifr.p1_done), 32'(c == 8 || c == 16));
            chk($sformatf("rr_c%0d_busy", c),   32'(ifr.busy),    32'(c % 4 != 0));
            if (c == 4 || c == 12) chk("rr_p0_rdata", ifr.p0_rdata, 32'hDEADBEEF);
            if (c == 8 || c == 16) chk("rr_p1_rdata", ifr.p1_rdata, 32'h12345678);
            if (c == 4 || c == 12) ifr.p0_req = 0;
            if (c == 5)            ifr.p0_req = 1;
            if (c == 8 || c == 16) ifr.p1_req = 0;
            if (c == 9)            ifr.p1_req = 1;
        end
        tick();

        // Out of range: byte address 256
        ifr.p0_req = 1; ifr.p0_we = 0; ifr.p0_addr = 32'd256;
        tick();
        chk("oor_done",  32'(ifr.p0_done), 1);
        chk("oor_err",   32'(ifr.p0_err), 1);
        chk("oor_rdata", ifr.p0_rdata, 0);
        chk("oor_mread", 32'(ifr.mem_read), 0);
        chk("oor_busy",  32'(ifr.busy), 0);
        ifr.p0_req = 0;
        tick();
        chk("oor_c2_done",  32'(ifr.p0_done), 0);
        chk("oor_c2_mread", 32'(ifr.mem_read), 0);
        chk("oor_c2_mwr",   32'(ifr.mem_write), 0);

        // Reset in the middle of a p0 write to addr 4
        ifr.p0_req = 1; ifr.p0_we = 1; ifr.p0_addr = 32'd4; ifr.p0_wdata = 32'h55AA55AA;
        tick();
        chk("rm_c1_busy", 32'(ifr.busy), 1);
        tick();
        chk("rm_c2_mwr", 32'(ifr.mem_write), 0);
        rst = 1'b1;
        ifr.p0_req = 0;
        #1;
        chk("rm_busy",   32'(ifr.busy), 0);
        chk("rm_mwr",    32'(ifr.mem_write), 0);
        chk("rm_maddr",  ifr.mem_addr, 0);
        chk("rm_mwdata", ifr.mem_wdata, 0);
        chk("rm_p1rd",   ifr.p1_rdata, 0);
        chk("rm_p0err",  32'(ifr.p0_err), 0);
        tick();
        tick();
        chk("rm_mem1",   mem_r[1], 32'hCAFEF00D);
        chk("rm_wrcnt",  32'(wr_cnt), 1);
        rst = 1'b0;
        tick();
        ifr.p0_req = 1; ifr.p0_we = 0; ifr.p0_addr = 32'd4;
        repeat (4) tick();
        chk("rm_new_done",  32'(ifr.p0_done), 1);
        chk("rm_new_rdata", ifr.p0_rdata, 32'hCAFEF00D);
        chk("rm_wrcnt2",    32'(wr_cnt), 1);
        ifr.p0_req = 0;
        tick();

        // Fixed priority, zero wait states: p0 wins ties even right after its own grant
        ifp.p0_req = 1; ifp.p0_we = 0; ifp.p0_addr = 32'h10;
        ifp.p1_we = 0; ifp.p1_addr = 32'h20;
        for (int c = 1; c <= 9; c++) begin
            tick();
            chk($sformatf("fp_c%0d_p0done", c), 32'(ifp.p0_done), 32'(c == 2 || c == 5 || c == 9));
            chk($sformatf("fp_c%0d_p1done", c), 32'(ifp.p1_done), 32'(c == 7));
            if (c == 2) chk("fp_p0_rdata", ifp.p0_rdata, 32'hA5A5A5B5);
            if (c == 6) chk("fp_c6_maddr", ifp.mem_addr, 32'h20);
            if (c == 7) chk("fp_p1_rdata", ifp.p1_rdata, 32'hA5A5A585);
            if (c == 2 || c == 5 || c == 9) ifp.p0_req = 0;
            if (c == 3) begin ifp.p0_req = 1; ifp.p1_req = 1; end
            if (c == 6) ifp.p0_req = 1;
            if (c == 7) ifp.p1_req = 0;
        end
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
